wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Two-master, one-slave Wishbone arbiter. It shares the 16-bit-address, 8-bit-data slave bus between the CPU-side Wishbone master (m0) and a second requester such as DMA or debug (m1). Arbitration is round-robin with a registered grant. The grant is held for a whole bus cycle (`cyc` high). A stall-timeout watchdog converts a missing `ack` into a one-cycle `err` back to the granted master.

## Interface
- `AW`, 16, address width
- `DW`, 8, data width
- `TIMEOUT`, 16, stall cycles tolerated before `err`; legal range ≥1; counter width `CW` = clog2(`TIMEOUT`+1)

- `clk_i`  in  1  single clock; all state updates on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-low (0 = reset)
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 bus-cycle request, strobe, write enable
- `m0_adr_i`  in  `AW`  master 0 address
- `m0_dat_i`  in  `DW`  master 0 write data
- `m0_dat_o`  out  `DW`  read data to master 0
- `m0_ack_o`, `m0_err_o`  out  1 each  acknowledge and timeout error to master 0
- `m1_*`  same set as `m0_*`, for master 1
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave bus control
- `s_adr_o`  out  `AW`  slave address
- `s_dat_o`  out  `DW`  slave write data
- `s_dat_i`  in  `DW`  slave read data
- `s_ack_i`  in  1  slave acknowledge
- `gnt_o`  out  2  registered one-hot grant: bit0 = m0, bit1 = m1, 00 = idle

## Operation
- **FSM states:** `IDLE`, `GNT0`, `GNT1`. Extra registers: `last` (1 bit, the most recently granted master) and `cnt` (`CW` bits).
- **Arbitration.** On each edge where the state is `IDLE`, or the granted master has `cyc_i`=0, the next state is chosen from the requests `m0_cyc_i` and `m1_cyc_i`:
  - no requester: `IDLE`;
  - exactly one requester: grant that master;
  - both request: grant the master that is not `last`.
  - A new grant updates `last`.
  - The releasing master's `cyc_i`=0 excludes it, so an edge can hand off directly from `GNT0` to `GNT1`.
- **Grant holding.** While in `GNTx` with `mx_cyc_i`=1, the grant is held regardless of the other master. There is no pre-emption.
- **Granted routing.**
  - `mx_cyc/stb/we/adr/dat_i` drive `s_*_o` combinationally.
  - `s_dat_i` drives `mx_dat_o`.
  - `mx_ack_o` = `s_ack_i` & `mx_stb_i`.
- **Non-granted master:** `dat_o`=0, `ack_o`=0, `err_o`=0.
- **`IDLE` outputs:** all `s_*_o` = 0.
- **Watchdog counter `cnt`.**
  - In `GNTx` with `s_stb_o`=1 and `s_ack_i`=0: `cnt` increments, saturating at `TIMEOUT`.
  - Otherwise (ack received, strobe low, state change, or `IDLE`): `cnt` clears to 0.
- **Timeout error.**
  - `mx_err_o` = `GNTx` & `mx_stb_i` & ~`s_ack_i` & (`cnt`==`TIMEOUT`).
  - In that cycle `s_stb_o` and `s_cyc_o` are forced to 0 and `cnt` clears.
  - The grant is kept until the master drops `cyc`.
- **Simultaneous ack and timeout:** `ack` wins; `err` is not asserted.
- **Reset values.** Asynchronous reset (`rst_i`=0) at any time, including mid-cycle:
  - state = `IDLE`, `last`=1, `cnt`=0;
  - all outputs 0, `gnt_o`=00.
  - After reset, m0 wins the first tie.

## Timing
- **Grant latency:** 1 cycle. A request seen at edge N gives `gnt_o` and `s_cyc_o` valid after edge N; the first slave strobe is visible in cycle N+1.
- **Data path:** combinational through the mux; there is no added latency on `ack` or read data.
- **Release:**
  - The edge that samples the granted `cyc_i`=0 re-arbitrates.
  - A hand-off to the other master has zero idle cycles.
  - With no other requester, the FSM enters `IDLE` for at least 1 cycle.
- **Timeout timing:** with a strobe stalled from cycle 0, `err` is asserted in stall cycle `TIMEOUT` (the (`TIMEOUT`+1)-th cycle), for exactly 1 cycle.

## Test plan
- **Single master.** After reset release, m0 does a write: `cyc`/`stb`/`we`=1, `adr`=16'h1234, `dat`=8'hA5; the slave acks 2 cycles later.
  - Required: `gnt_o`=01 one edge later; `s_adr_o`=1234, `s_dat_o`=A5; `m0_ack_o` pulses; `IDLE` after `cyc` drops.
- **Tie and round-robin.** Both masters raise `cyc` in the same cycle after reset.
  - Required: m0 is granted first. When m0 drops `cyc`, `GNT1` follows on the next edge with no idle cycle.
  - A second tie is then granted to m0.
- **No pre-emption.** m1 requests while m0 holds a 5-cycle burst.
  - Required: `gnt_o` stays 01 and `m1_ack_o` stays 0 throughout; m1 is granted on the edge after m0's `cyc` falls.
- **Timeout.** `TIMEOUT`=4; m0 strobes address 16'h00FF and the slave never acks.
  - Required: `m0_err_o`=1 in exactly the 5th stall cycle, with `s_stb_o`=0 in that cycle; `cnt` returns to 0; the next ack works normally.
- **Ack on the boundary.** `TIMEOUT`=4; the slave acks in stall cycle 4.
  - Required: `m0_ack_o`=1 and `m0_err_o`=0.
- **Reset mid-cycle.** Assert `rst_i`=0 asynchronously during a `GNT1` read.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge.
  - After release with both masters requesting, m0 is granted.

Source files
------------

// File: rtl/wishbone_arbiter_if.sv
// rtl/wishbone_arbiter_if.sv - Wishbone bus bundles for the arbiter's master-facing and slave-facing ports.
// The slave-side bundle has no err: timeouts are generated inside the arbiter.

interface wishbone_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, adr, wdat, input rdat, ack, err);
  modport slave  (input cyc, stb, we, adr, wdat, output rdat, ack, err);
endinterface

interface wishbone_arbiter_sbus_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic [DW-1:0] rdat;
  logic          ack;

  modport master (output cyc, stb, we, adr, wdat, input rdat, ack);
  modport slave  (input cyc, stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - Two-master round-robin Wishbone arbiter with registered grant.
// A stall watchdog turns a missing slave ack into a one-cycle err to the granted master.

module wishbone_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wishbone_arbiter_if.slave       m0,
  wishbone_arbiter_if.slave       m1,
  wishbone_arbiter_sbus_if.master s,
  output logic [1:0]              gnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        pick;
  logic          last;
  logic [CW-1:0] cnt;

  logic          sel_cyc;
  logic          sel_stb;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdat;
  logic          hold;
  logic          timeout;
  logic          err_now;

  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_adr  = '0;
    sel_wdat = '0;
    case (state)
      GNT0: begin
        sel_cyc  = m0.cyc;
        sel_stb  = m0.stb;
        sel_we   = m0.we;
        sel_adr  = m0.adr;
        sel_wdat = m0.wdat;
      end
      GNT1: begin
        sel_cyc  = m1.cyc;
        sel_stb  = m1.stb;
        sel_we   = m1.we;
        sel_adr  = m1.adr;
        sel_wdat = m1.wdat;
      end
      default: ;
    endcase
  end

  // An ack in the same cycle as the timeout suppresses err.
  assign timeout = (cnt == CW'(TIMEOUT));
  assign err_now = (state != IDLE) & sel_stb & ~s.ack & timeout;

  assign s.cyc  = sel_cyc & ~err_now;
  assign s.stb  = sel_stb & ~err_now;
  assign s.we   = sel_we;
  assign s.adr  = sel_adr;
  assign s.wdat = sel_wdat;

  assign m0.rdat = (state == GNT0) ? s.rdat : '0;
  assign m0.ack  = (state == GNT0) & s.ack & m0.stb;
  assign m0.err  = (state == GNT0) & err_now;
  assign m1.rdat = (state == GNT1) ? s.rdat : '0;
  assign m1.ack  = (state == GNT1) & s.ack & m1.stb;
  assign m1.err  = (state == GNT1) & err_now;

  assign hold = ((state == GNT0) & m0.cyc) | ((state == GNT1) & m1.cyc);

  // A releasing master has cyc low, so it can never win its own re-arbitration.
  always_comb begin
    pick = IDLE;
    if (m0.cyc && m1.cyc) begin
      pick = last ? GNT0 : GNT1;
    end else if (m0.cyc) begin
      pick = GNT0;
    end else if (m1.cyc) begin
      pick = GNT1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      gnt_o <= 2'b00;
    end else if (hold) begin
      if (s.stb && !s.ack) begin
        cnt <= timeout ? cnt : cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end else begin
      state <= pick;
      cnt   <= '0;
      case (pick)
        GNT0:    gnt_o <= 2'b01;
        GNT1:    gnt_o <= 2'b10;
        default: gnt_o <= 2'b00;
      endcase
      if (pick != IDLE) begin
        last <= (pick == GNT1);
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - Directed and randomized bench for wishbone_arbiter.
// Random phase compares against a per-cycle ownership/stall model.

module tb_wishbone_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  wishbone_arbiter_if      #(.AW(AW), .DW(DW)) m0_bus ();
  wishbone_arbiter_if      #(.AW(AW), .DW(DW)) m1_bus ();
  wishbone_arbiter_sbus_if #(.AW(AW), .DW(DW)) s_bus ();

  wishbone_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .gnt_o (gnt)
  );

  logic          r_cyc [2];
  logic          r_stb [2];
  logic          r_we  [2];
  logic [AW-1:0] r_adr [2];
  logic [DW-1:0] r_dat [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int idx, input logic c, input logic st, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx == 0) begin
      m0_bus.cyc = c; m0_bus.stb = st; m0_bus.we = w; m0_bus.adr = a; m0_bus.wdat = d;
    end else begin
      m1_bus.cyc = c; m1_bus.stb = st; m1_bus.we = w; m1_bus.adr = a; m1_bus.wdat = d;
    end
  endtask

  task automatic clear_inputs();
    drive_m(0, 0, 0, 0, '0, '0);
    drive_m(1, 0, 0, 0, '0, '0);
    s_bus.ack  = 1'b0;
    s_bus.rdat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_m(0, 1, 1, 1, 16'h1111, 8'h11);
    drive_m(1, 1, 1, 0, 16'h2222, 8'h22);
    s_bus.ack = 1'b1;
    tick();
    tick();
    #2;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++;
    if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b000) begin
      errors++; $display("FAIL reset_sctl got %b exp 000", {s_bus.cyc, s_bus.stb, s_bus.we});
    end
    checks++;
    if ({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err got %b exp 0000", {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err});
    end
    clear_inputs();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    drive_m(0, 1, 1, 1, 16'h1234, 8'hA5);
    #2;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL single_pre_gnt got %b exp 00", gnt); end
    tick();
    #2;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b exp 01", gnt); end
    checks++;
    if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b111) begin
      errors++; $display("FAIL single_sctl got %b exp 111", {s_bus.cyc, s_bus.stb, s_bus.we});
    end
    checks++;
    if (s_bus.adr !== 16'h1234 || s_bus.wdat !== 8'hA5) begin
      errors++; $display("FAIL single_adr_dat got %h/%h exp 1234/a5", s_bus.adr, s_bus.wdat);
    end
    checks++;
    if (m0_bus.ack !== 1'b0) begin errors++; $display("FAIL single_early_ack got %b exp 0", m0_bus.ack); end
    tick();
    tick();
    s_bus.ack = 1'b1;
    #2;
    checks++;
    if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0) begin
      errors++; $display("FAIL single_ack got ack=%b err=%b exp ack=1 err=0", m0_bus.ack, m0_bus.err);
    end
    tick();
    s_bus.ack = 1'b0;
    drive_m(0, 0, 0, 0, '0, '0);
    #2;
    checks++;
    if (gnt !== 2'b01 || s_bus.cyc !== 1'b0) begin
      errors++; $display("FAIL single_release got gnt=%b cyc=%b exp gnt=01 cyc=0", gnt, s_bus.cyc);
    end
    tick();
    #2;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", gnt); end
  endtask

  task automatic test_tie();
    do_reset();
    drive_m(0, 1, 1, 0, 16'h1000, 8'h11);
    drive_m(1, 1, 1, 1, 16'h2000, 8'h22);
    s_bus.ack  = 1'b1;
    s_bus.rdat = 8'h3C;
    tick();
    #2;
    checks++;
    if (gnt !== 2'b01 || s_bus.adr !== 16'h1000) begin
      errors++; $display("FAIL tie_first got gnt=%b adr=%h exp gnt=01 adr=1000", gnt, s_bus.adr);
    end
    checks++;
    if ({m0_bus.ack, m1_bus.ack} !== 2'b10 || m0_bus.rdat !== 8'h3C || m1_bus.rdat !== 8'h00) begin
      errors++; $display("FAIL tie_route got ack=%b rdat0=%h rdat1=%h exp ack=10 rdat0=3c rdat1=00",
                         {m0_bus.ack, m1_bus.ack}, m0_bus.rdat, m1_bus.rdat);
    end
    tick();
    drive_m(0, 0, 0, 0, '0, '0);
    tick();
    #2;
    checks++;
    if (gnt !== 2'b10 || s_bus.adr !== 16'h2000 || s_bus.we !== 1'b1) begin
      errors++; $display("FAIL tie_handoff got gnt=%b adr=%h we=%b exp gnt=10 adr=2000 we=1", gnt, s_bus.adr, s_bus.we);
    end
    checks++;
    if ({m0_bus.ack, m1_bus.ack} !== 2'b01) begin
      errors++; $display("FAIL tie_m1_ack got %b exp 01", {m0_bus.ack, m1_bus.ack});
    end
    drive_m(1, 0, 0, 0, '0, '0);
    tick();
    #2;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL tie_idle got %b exp 00", gnt); end
    drive_m(0, 1, 1, 0, 16'h1000, 8'h11);
    drive_m(1, 1, 1, 1, 16'h2000, 8'h22);
    tick();
    #2;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL tie_second got %b exp 01", gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_no_preempt();
    do_reset();
    s_bus.ack = 1'b1;
    drive_m(0, 1, 1, 1, 16'h0040, 8'h40);
    tick();
    drive_m(1, 1, 1, 0, 16'h0080, 8'h80);
    for (int k = 0; k < 5; k++) begin
      #2;
      checks++;
      if (gnt !== 2'b01 || m1_bus.ack !== 1'b0 || m0_bus.ack !== 1'b1) begin
        errors++; $display("FAIL preempt_hold%0d got gnt=%b ack0=%b ack1=%b exp gnt=01 ack0=1 ack1=0",
                           k, gnt, m0_bus.ack, m1_bus.ack);
      end
      tick();
    end
    drive_m(0, 0, 0, 0, '0, '0);
    #2;
    checks++;
    if (gnt !== 2'b01 || m1_bus.ack !== 1'b0) begin
      errors++; $display("FAIL preempt_release got gnt=%b ack1=%b exp gnt=01 ack1=0", gnt, m1_bus.ack);
    end
    tick();
    #2;
    checks++;
    if (gnt !== 2'b10 || m1_bus.ack !== 1'b1) begin
      errors++; $display("FAIL preempt_m1 got gnt=%b ack1=%b exp gnt=10 ack1=1", gnt, m1_bus.ack);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic exp_err;
    do_reset();
    drive_m(0, 1, 1, 0, 16'h00FF, 8'h00);
    tick();
    for (int k = 0; k <= 5; k++) begin
      exp_err = (k == TO);
      #2;
      checks++;
      if (m0_bus.err !== exp_err || s_bus.stb !== !exp_err || s_bus.cyc !== !exp_err) begin
        errors++; $display("FAIL timeout_c%0d got err=%b stb=%b cyc=%b exp err=%b stb=%b cyc=%b",
                           k, m0_bus.err, s_bus.stb, s_bus.cyc, exp_err, !exp_err, !exp_err);
      end
      if (k == 5) begin
        checks++;
        if (dut.cnt !== '0) begin errors++; $display("FAIL timeout_cnt_clear got %0d exp 0", dut.cnt); end
      end
      tick();
    end
    s_bus.ack = 1'b1;
    #2;
    checks++;
    if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0 || gnt !== 2'b01) begin
      errors++; $display("FAIL timeout_next_ack got ack=%b err=%b gnt=%b exp ack=1 err=0 gnt=01",
                         m0_bus.ack, m0_bus.err, gnt);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_ack_boundary();
    do_reset();
    drive_m(0, 1, 1, 0, 16'h00FF, 8'h00);
    tick();
    for (int k = 0; k < TO; k++) begin
      #2;
      checks++;
      if (m0_bus.err !== 1'b0 || m0_bus.ack !== 1'b0) begin
        errors++; $display("FAIL boundary_stall%0d got ack=%b err=%b exp 0/0", k, m0_bus.ack, m0_bus.err);
      end
      tick();
    end
    s_bus.ack = 1'b1;
    #2;
    checks++;
    if (m0_bus.ack !== 1'b1 || m0_bus.err !== 1'b0 || s_bus.stb !== 1'b1) begin
      errors++; $display("FAIL boundary_ack got ack=%b err=%b stb=%b exp ack=1 err=0 stb=1",
                         m0_bus.ack, m0_bus.err, s_bus.stb);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m(1, 1, 1, 0, 16'hABCD, 8'h00);
    s_bus.rdat = 8'h5C;
    s_bus.ack  = 1'b1;
    tick();
    #2;
    checks++;
    if (gnt !== 2'b10 || m1_bus.rdat !== 8'h5C || m1_bus.ack !== 1'b1) begin
      errors++; $display("FAIL rstmid_read got gnt=%b rdat=%h ack=%b exp gnt=10 rdat=5c ack=1",
                         gnt, m1_bus.rdat, m1_bus.ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || {s_bus.cyc, s_bus.stb} !== 2'b00 || s_bus.adr !== 16'h0000) begin
      errors++; $display("FAIL rstmid_bus got gnt=%b cyc=%b stb=%b adr=%h exp 00/0/0/0000",
                         gnt, s_bus.cyc, s_bus.stb, s_bus.adr);
    end
    checks++;
    if (m1_bus.ack !== 1'b0 || m1_bus.rdat !== 8'h00) begin
      errors++; $display("FAIL rstmid_m1 got ack=%b rdat=%h exp 0/00", m1_bus.ack, m1_bus.rdat);
    end
    drive_m(0, 1, 1, 0, 16'h0001, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    #2;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_tie got %b exp 01", gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int       own;
    int       last_m;
    int       stall;
    logic     ack_in;
    logic [DW-1:0] rd_in;
    logic     ex_err;
    logic [1:0] ex_gnt;
    logic     ex_cyc, ex_stb, ex_we;
    logic [AW-1:0] ex_adr;
    logic [DW-1:0] ex_wdat;
    logic [3:0] ex_ae;
    logic [DW-1:0] ex_rd0, ex_rd1;
    do_reset();
    own = -1; last_m = 1; stall = 0;
    for (int i = 0; i < 2; i++) begin
      r_cyc[i] = 0; r_stb[i] = 0; r_we[i] = 0; r_adr[i] = '0; r_dat[i] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (r_cyc[i]) r_cyc[i] = ($urandom_range(7) != 0);
        else          r_cyc[i] = ($urandom_range(3) == 0);
        r_stb[i] = r_cyc[i] && ($urandom_range(3) != 0);
        r_we[i]  = 1'($urandom);
        r_adr[i] = AW'($urandom);
        r_dat[i] = DW'($urandom);
        drive_m(i, r_cyc[i], r_stb[i], r_we[i], r_adr[i], r_dat[i]);
      end
      ack_in = (n < 1500) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      rd_in  = DW'($urandom);
      s_bus.ack  = ack_in;
      s_bus.rdat = rd_in;

      ex_err  = (own >= 0) && r_stb[own] && !ack_in && (stall == TO);
      ex_gnt  = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
      ex_cyc  = (own >= 0) && r_cyc[own] && !ex_err;
      ex_stb  = (own >= 0) && r_stb[own] && !ex_err;
      ex_we   = (own >= 0) && r_we[own];
      ex_adr  = (own >= 0) ? r_adr[own] : '0;
      ex_wdat = (own >= 0) ? r_dat[own] : '0;
      ex_ae   = {(own == 0) && ack_in && r_stb[0], (own == 0) && ex_err,
                 (own == 1) && ack_in && r_stb[1], (own == 1) && ex_err};
      ex_rd0  = (own == 0) ? rd_in : '0;
      ex_rd1  = (own == 1) ? rd_in : '0;
      #2;
      checks++;
      if ({gnt, s_bus.cyc, s_bus.stb, s_bus.we} !== {ex_gnt, ex_cyc, ex_stb, ex_we}) begin
        errors++; $display("FAIL rand_ctl cyc%0d got %b exp %b", n,
                           {gnt, s_bus.cyc, s_bus.stb, s_bus.we}, {ex_gnt, ex_cyc, ex_stb, ex_we});
      end
      checks++;
      if (s_bus.adr !== ex_adr || s_bus.wdat !== ex_wdat) begin
        errors++; $display("FAIL rand_addr cyc%0d got %h/%h exp %h/%h", n, s_bus.adr, s_bus.wdat, ex_adr, ex_wdat);
      end
      checks++;
      if ({m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err} !== ex_ae) begin
        errors++; $display("FAIL rand_ack_err cyc%0d got %b exp %b", n,
                           {m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err}, ex_ae);
      end
      checks++;
      if (m0_bus.rdat !== ex_rd0 || m1_bus.rdat !== ex_rd1) begin
        errors++; $display("FAIL rand_rdat cyc%0d got %h/%h exp %h/%h", n, m0_bus.rdat, m1_bus.rdat, ex_rd0, ex_rd1);
      end

      if (own < 0 || !r_cyc[own]) begin
        stall = 0;
        if (r_cyc[0] && r_cyc[1]) own = 1 - last_m;
        else if (r_cyc[0])        own = 0;
        else if (r_cyc[1])        own = 1;
        else                      own = -1;
        if (own >= 0) last_m = own;
      end else if (r_stb[own] && !ack_in && !ex_err) begin
        stall = (stall < TO) ? stall + 1 : TO;
      end else begin
        stall = 0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_no_preempt();
    test_timeout();
    test_ack_boundary();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
